proc_run_controller: RTL and testbench
======================================

PROC_RUN_CONTROLLER -- requirements
Module: proc_run_controller

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16; RUN tick period is 2^DIV_WIDTH cycles.
REQ-002 SHALL have parameter PC_WIDTH, default 32; width of all PC ports.
REQ-003 SHALL have port pixel_clk_in, input, 1: sole clock.
REQ-004 SHALL have port rst_in, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port load_done_in, input, 1: level, high while instruction memory is fully loaded.
REQ-006 SHALL have port run_in, input, 1: single-cycle pulse requesting free-running execution.
REQ-007 SHALL have port step_in, input, 1: single-cycle pulse requesting one instruction.
REQ-008 SHALL have port halt_in, input, 1: single-cycle pulse requesting pause.
REQ-009 SHALL have port pc_in, input, PC_WIDTH: processor PC of the most recently retired instruction.
REQ-010 SHALL have port ending_pc_in, input, PC_WIDTH: last program PC.
REQ-011 SHALL have port instr_done_in, input, 1: single-cycle pulse on instruction retire.
REQ-012 SHALL have port proc_rst_out, output, 1: processor reset.
REQ-013 SHALL have port proc_en_out, output, 1: single-cycle processor clock enable.
REQ-014 SHALL have port state_out, output, 3: current state encoding.
REQ-015 SHALL have port halted_out, output, 1: high in DONE.
REQ-016 SHALL have port fault_out, output, 1: sticky step-timeout flag.
REQ-017 SHALL have port step_count_out, output, 32: enables issued since last LOAD.

Function
REQ-018 SHALL implement states LOAD, IDLE, RUN, STEP_WAIT and DONE.
REQ-019 SHALL hold proc_rst_out high exactly while in LOAD; all outputs are registered.
REQ-020 SHALL leave LOAD for IDLE on the first cycle load_done_in is high.
REQ-021 SHALL enter LOAD from any state on the cycle after load_done_in is sampled low; this has the highest priority.
REQ-022 SHALL resolve same-cycle requests in priority order halt_in > run_in > step_in.
REQ-023 SHALL, in IDLE, move to RUN on run_in; a step_in moves to STEP_WAIT with proc_en_out high for the next cycle only.
REQ-024 SHALL clear the divider on RUN entry and pulse proc_en_out once every 2^DIV_WIDTH cycles; first pulse 2^DIV_WIDTH cycles after entry.
REQ-025 SHALL, in RUN, return to IDLE on halt_in with no further proc_en_out pulses; the divider is discarded.
REQ-026 SHALL, in RUN or STEP_WAIT, enter DONE when instr_done_in is high and pc_in == ending_pc_in (full-width compare).
REQ-027 SHALL, in STEP_WAIT, return to IDLE on instr_done_in when the PC does not match.
REQ-028 SHALL, in STEP_WAIT, set fault_out and return to IDLE if 2^DIV_WIDTH cycles pass without instr_done_in.
REQ-029 SHALL ignore run_in, step_in and halt_in in STEP_WAIT, DONE and LOAD.
REQ-030 SHALL leave DONE only via REQ-021 or rst_in; proc_en_out stays 0 in DONE.
REQ-031 SHALL increment step_count_out once per proc_en_out pulse, saturate at 2^32-1, and clear on LOAD entry.
REQ-032 SHALL clear fault_out only on LOAD entry or rst_in.
REQ-033 SHALL ignore instr_done_in in IDLE and LOAD.

Reset
REQ-034 SHALL, on rst_in, set state LOAD, proc_rst_out=1, proc_en_out=0, halted_out=0, fault_out=0, step_count_out=0, divider=0 and timeout counter=0.
REQ-035 SHALL let rst_in override any in-flight tick or step on the same edge.

Structure
REQ-036 SHALL place the state enum (LOAD=0, IDLE=1, RUN=2, STEP_WAIT=3, DONE=4) in shared package proc_ctrl_pkg.
REQ-037 SHALL place the default DIV_WIDTH constant in proc_ctrl_pkg.
REQ-038 SHALL implement the divider/timeout counter as sub-module tick_divider (clear, enable, wrap pulse), reused by RUN and STEP_WAIT.

Verification (bench DIV_WIDTH=4)
REQ-039 SHALL check: reset, then load_done_in=1 at cycle 5 -> proc_rst_out high through cycle 5, IDLE at cycle 6, proc_en_out=0.
REQ-040 SHALL check: run_in in IDLE -> proc_en_out pulses exactly every 16 cycles, first 16 after entry; halt_in after 3 pulses -> IDLE, step_count_out=3.
REQ-041 SHALL check: step_in in IDLE -> one proc_en_out pulse; instr_done_in 3 cycles later with pc_in=0x8, ending_pc_in=0x20 -> IDLE, step_count_out=1.
REQ-042 SHALL check: RUN, instr_done_in with pc_in=ending_pc_in=0x6C -> DONE, halted_out=1, no further pulses for 64 cycles.
REQ-043 SHALL check: step_in with no instr_done_in for 16 cycles -> fault_out=1, IDLE; drop load_done_in -> LOAD, fault_out=0, step_count_out=0.
REQ-044 SHALL check: halt_in, run_in and step_in in the same cycle in RUN -> IDLE; run_in with step_in in IDLE -> RUN.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the processor run controller.
package proc_ctrl_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_DONE      = 3'd4
  } proc_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running 2^WIDTH cycle divider; shared by the RUN tick and the STEP_WAIT timeout.
module tick_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Independent of clr_i so the parent can derive clr_i from its next state.
  assign wrap_o = en_i && (cnt_q == '1);

endmodule

// File: rtl/proc_run_controller.sv
// Load/run/step/halt sequencer for a soft processor; all outputs are registered.
// state | meaning: LOAD imem loading, proc held in reset | IDLE paused | RUN free-running ticks
//       | STEP_WAIT one enable issued, awaiting retire | DONE ending PC retired
module proc_run_controller
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEFAULT,
  parameter int unsigned PC_WIDTH  = 32
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic                load_done_in,
  input  logic                run_in,
  input  logic                step_in,
  input  logic                halt_in,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic [PC_WIDTH-1:0] ending_pc_in,
  input  logic                instr_done_in,
  output logic                proc_rst_out,
  output logic                proc_en_out,
  output logic [2:0]          state_out,
  output logic                halted_out,
  output logic                fault_out,
  output logic [31:0]         step_count_out
);

  proc_state_e state_q, state_d;
  logic        proc_rst_q, proc_en_q, halted_q, fault_q;
  logic        proc_en_d, fault_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic        pc_match, tick_wrap, div_en, div_clr;

  assign pc_match = instr_done_in && (pc_in == ending_pc_in);
  assign div_en   = (state_q == ST_RUN) || (state_q == ST_STEP_WAIT);
  assign div_clr  = (state_d != state_q);

  tick_divider #(.WIDTH(DIV_WIDTH)) u_tick_divider (
    .clk_i  (pixel_clk_in),
    .rst_i  (rst_in),
    .clr_i  (div_clr),
    .en_i   (div_en),
    .wrap_o (tick_wrap)
  );

  always_comb begin
    state_d   = state_q;
    proc_en_d = 1'b0;
    fault_d   = fault_q;
    if (!load_done_in) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: state_d = ST_IDLE;
        ST_IDLE: begin
          // halt masks run/step even though IDLE is already paused
          if (halt_in)      state_d = ST_IDLE;
          else if (run_in)  state_d = ST_RUN;
          else if (step_in) begin
            state_d   = ST_STEP_WAIT;
            proc_en_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (pc_match)       state_d = ST_DONE;
          else if (halt_in)   state_d = ST_IDLE;
          else if (tick_wrap) proc_en_d = 1'b1;
        end
        ST_STEP_WAIT: begin
          if (pc_match)           state_d = ST_DONE;
          else if (instr_done_in) state_d = ST_IDLE;
          else if (tick_wrap) begin
            state_d = ST_IDLE;
            fault_d = 1'b1;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_LOAD;
      endcase
    end
    if (state_d == ST_LOAD) fault_d = 1'b0;
    if (state_d == ST_LOAD) step_cnt_d = '0;
    else if (proc_en_d)     step_cnt_d = sat_inc32(step_cnt_q);
    else                    step_cnt_d = step_cnt_q;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q    <= ST_LOAD;
      proc_rst_q <= 1'b1;
      proc_en_q  <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      proc_rst_q <= (state_d == ST_LOAD);
      proc_en_q  <= proc_en_d;
      halted_q   <= (state_d == ST_DONE);
      fault_q    <= fault_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign proc_rst_out   = proc_rst_q;
  assign proc_en_out    = proc_en_q;
  assign state_out      = state_q;
  assign halted_out     = halted_q;
  assign fault_out      = fault_q;
  assign step_count_out = step_cnt_q;

endmodule

// File: tb/tb_proc_run_controller.sv
// Directed bench for proc_run_controller with a 16-cycle tick (DIV_WIDTH=4).
module tb_proc_run_controller;
  import proc_ctrl_pkg::*;

  localparam int DW  = 4;
  localparam int PW  = 32;
  localparam int PER = 1 << DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_done = 1'b0;
  logic          run = 1'b0, step = 1'b0, halt = 1'b0, instr_done = 1'b0;
  logic [PW-1:0] pc = '0, end_pc = '0;
  logic          proc_rst, proc_en, halted, fault;
  logic [2:0]    state;
  logic [31:0]   step_count;

  int nvec = 0;
  int nmis = 0;

  proc_run_controller #(.DIV_WIDTH(DW), .PC_WIDTH(PW)) dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .load_done_in   (load_done),
    .run_in         (run),
    .step_in        (step),
    .halt_in        (halt),
    .pc_in          (pc),
    .ending_pc_in   (end_pc),
    .instr_done_in  (instr_done),
    .proc_rst_out   (proc_rst),
    .proc_en_out    (proc_en),
    .state_out      (state),
    .halted_out     (halted),
    .fault_out      (fault),
    .step_count_out (step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic r, input logic s, input logic h);
    run = r; step = s; halt = h;
    tick(1);
    run = 1'b0; step = 1'b0; halt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    tick(2);
    chk("rst_state", state, ST_LOAD);
    chk("rst_proc_rst", proc_rst, 1);
    chk("rst_proc_en", proc_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_count", step_count, 0);
    rst = 1'b0;

    // held in LOAD until load_done
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      chk("load_proc_rst", proc_rst, 1);
      chk("load_state", state, ST_LOAD);
    end
    load_done = 1'b1;
    tick(1);
    chk("idle_state", state, ST_IDLE);
    chk("idle_proc_rst", proc_rst, 0);
    chk("idle_proc_en", proc_en, 0);

    // RUN: pulse every 16 cycles, first 16 after entry
    pulse(1, 0, 0);
    chk("run_state", state, ST_RUN);
    for (int i = 1; i <= 3 * PER; i++) begin
      tick(1);
      chk("run_en", proc_en, (i % PER == 0) ? 1 : 0);
    end
    chk("run_count3", step_count, 3);
    pulse(0, 0, 1);
    chk("halt_state", state, ST_IDLE);
    chk("halt_count", step_count, 3);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("halt_no_en", proc_en, 0);
    end

    // rst on the same edge as a pending RUN tick
    pulse(1, 0, 0);
    tick(PER - 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_tick_en", proc_en, 0);
    chk("rst_tick_state", state, ST_LOAD);
    chk("rst_tick_count", step_count, 0);
    tick(1);
    chk("rst_tick_idle", state, ST_IDLE);

    // single step, non-matching retire
    pulse(0, 1, 0);
    chk("step_state", state, ST_STEP_WAIT);
    chk("step_en", proc_en, 1);
    chk("step_count", step_count, 1);
    tick(1);
    chk("step_en_once", proc_en, 0);
    tick(1);
    pc = 32'h8; end_pc = 32'h20; instr_done = 1'b1;
    tick(1);
    instr_done = 1'b0;
    chk("step_ret_state", state, ST_IDLE);
    chk("step_ret_count", step_count, 1);
    chk("step_ret_fault", fault, 0);

    // retire in IDLE is ignored even on matching PC
    pc = 32'h20; instr_done = 1'b1;
    tick(1);
    instr_done = 1'b0;
    chk("idle_ign_retire", state, ST_IDLE);

    // RUN to DONE; high-bit PC difference must not match
    pulse(1, 0, 0);
    tick(5);
    pc = 32'h8000_006C; end_pc = 32'h6C; instr_done = 1'b1;
    tick(1);
    chk("near_miss_pc", state, ST_RUN);
    pc = 32'h6C;
    tick(1);
    instr_done = 1'b0;
    chk("done_state", state, ST_DONE);
    chk("done_halted", halted, 1);
    for (int i = 1; i <= 64; i++) begin
      run = (i == 10); step = (i == 20); halt = (i == 30);
      tick(1);
      chk("done_no_en", proc_en, 0);
    end
    run = 1'b0; step = 1'b0; halt = 1'b0;
    chk("done_stays", state, ST_DONE);
    chk("done_count", step_count, 1);

    // leave DONE via load_done, then step timeout
    load_done = 1'b0;
    tick(1);
    chk("reload_state", state, ST_LOAD);
    chk("reload_halted", halted, 0);
    load_done = 1'b1;
    tick(1);
    pulse(0, 1, 0);
    chk("to_en", proc_en, 1);
    for (int k = 1; k <= PER; k++) begin
      tick(1);
      if (k < PER) chk("to_wait", state, ST_STEP_WAIT);
    end
    chk("to_state", state, ST_IDLE);
    chk("to_fault", fault, 1);
    chk("to_no_en", proc_en, 0);
    tick(3);
    chk("fault_sticky", fault, 1);
    load_done = 1'b0;
    tick(1);
    chk("drop_state", state, ST_LOAD);
    chk("drop_fault", fault, 0);
    chk("drop_count", step_count, 0);
    chk("drop_proc_rst", proc_rst, 1);
    load_done = 1'b1;
    tick(1);

    // same-cycle request priority
    pulse(1, 0, 0);
    tick(4);
    pulse(1, 1, 1);
    chk("prio_halt", state, ST_IDLE);
    chk("prio_halt_en", proc_en, 0);
    pulse(1, 1, 0);
    chk("prio_run", state, ST_RUN);
    chk("prio_run_en", proc_en, 0);
    tick(PER);
    chk("prio_first_tick", proc_en, 1);
    chk("prio_count", step_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
